// File: rtl/seq_program_top.sv
// Fixed four-step register program: runs once after reset release,
// then parks in DONE with the results held on a/b/c/d.
module seq_program_top #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned A_INIT = 5,
  parameter int unsigned B_INIT = 9
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d
);

  localparam logic [WIDTH-1:0] AI  = WIDTH'(A_INIT);
  localparam logic [WIDTH-1:0] BI  = WIDTH'(B_INIT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [2:0] {
    START,
    S0,
    S1,
    S2,
    S3,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= START;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  // START performs the S0 load itself, so S0 is only a fallback encoding.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    unique case (state_q)
      START, S0: begin
        a_d     = AI;
        b_d     = BI;
        c_d     = '0;
        d_d     = '0;
        state_d = S1;
      end
      S1: begin
        a_d     = a_q + b_q;
        c_d     = b_q;
        state_d = S2;
      end
      S2: begin
        b_d     = '0;
        c_d     = c_q - BI;
        state_d = S3;
      end
      S3: begin
        d_d     = ONE;
        state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = START;
      end
    endcase
  end

  assign a = a_q;
  assign b = b_q;
  assign c = c_q;
  assign d = d_q;

endmodule

// File: tb/tb_seq_program_top.sv
// Directed bench: default program plus a wrapping instance (250, 10),
// checked after each edge, across mid-run and DONE resets.
module tb_seq_program_top;

  logic       clk;
  logic       rst;
  logic [7:0] a, b, c, d;
  logic [7:0] wa, wb, wc, wd;

  int total;
  int bad;

  seq_program_top #(
    .WIDTH (8),
    .A_INIT(5),
    .B_INIT(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d)
  );

  seq_program_top #(
    .WIDTH (8),
    .A_INIT(250),
    .B_INIT(10)
  ) dut_w (
    .clk(clk),
    .rst(rst),
    .a  (wa),
    .b  (wb),
    .c  (wc),
    .d  (wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected (a,b,c,d) after edges 1..4, worked by hand.
  logic [31:0] exp_n [4];
  logic [31:0] exp_w [4];

  task automatic run_prog(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_e%0d", tag, i + 1), {a, b, c, d}, exp_n[i]);
      chk($sformatf("%s_w_e%0d", tag, i + 1), {wa, wb, wc, wd}, exp_w[i]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_n[0] = {8'd5,  8'd9,  8'd0,  8'd0};
    exp_n[1] = {8'd14, 8'd9,  8'd9,  8'd0};
    exp_n[2] = {8'd14, 8'd0,  8'd0,  8'd0};
    exp_n[3] = {8'd14, 8'd0,  8'd0,  8'd1};
    exp_w[0] = {8'd250, 8'd10, 8'd0,  8'd0};
    exp_w[1] = {8'd4,   8'd10, 8'd10, 8'd0};
    exp_w[2] = {8'd4,   8'd0,  8'd0,  8'd0};
    exp_w[3] = {8'd4,   8'd0,  8'd0,  8'd1};

    rst = 1'b0;
    #2;
    chk("rst_init", {a, b, c, d}, 32'h0);
    @(negedge clk);
    chk("rst_hold", {a, b, c, d}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_prog("run1");

    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      chk("done_hold", {a, b, c, d}, exp_n[3]);
    end
    chk("done_hold_w", {wa, wb, wc, wd}, exp_w[3]);

    // Reset between edges: clear must not wait for a clock.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_e2", {a, b, c, d}, exp_n[1]);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_async", {a, b, c, d}, 32'h0);
    chk("mid_async_w", {wa, wb, wc, wd}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_prog("run2");

    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    chk("done2", {a, b, c, d}, exp_n[3]);
    #1;
    rst = 1'b0;
    #1;
    chk("done_async", {a, b, c, d}, 32'h0);
    chk("done_async_d", {24'h0, d}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_prog("run3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
